// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Wide adder built from one Width-bit ripple-carry slice. The slice is reused
// once per cycle, least-significant word first. The carry between words is
// kept in a register. An addition of Width*Words bits takes Words cycles after
// accept, and the result is presented through a valid/ready handshake.
//
// Optional feature macro: MWADD_SUB_EN
//   When it is defined, the sub_i port is added. It is sampled at accept.
//   With sub_i=1 the block computes add1_i - add2_i as add1_i + ~add2_i + 1.
//   In that case carry_o=1 means no borrow occurred.
//
// Parameters
//   Width : bit width of the adder slice (one word)
//   Words : number of words per operand (must be >= 2)
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_ni      in   asynchronous active-low reset
//   in_valid_i  in   operands valid
//   in_ready_o  out  block can accept operands (IDLE)
//   add1_i      in   first operand, Width*Words bits
//   add2_i      in   second operand, Width*Words bits
//   sub_i       in   subtract select (only with MWADD_SUB_EN)
//   out_valid_o out  result valid (DONE)
//   out_ready_i in   consumer accepts result
//   sum_o       out  last completed sum, registered
//   carry_o     out  carry out of the most-significant word, registered
//   busy_o      out  high while words are being processed
// ---------------------------------------------------------------------------
module multiword_add_seq #(
  parameter int Width = 32,
  parameter int Words = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [Width*Words-1:0] add1_i,
  input  logic [Width*Words-1:0] add2_i,
`ifdef MWADD_SUB_EN
  input  logic                   sub_i,
`endif
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [Width*Words-1:0] sum_o,
  output logic                   carry_o,
  output logic                   busy_o
);

  localparam int TotW = Width * Words;
  localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Words - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operand shift registers, the partial result and the inter-word carry.
  logic [TotW-1:0] r_op1;
  logic [TotW-1:0] r_op2;
  logic [TotW-1:0] r_res;
  logic            r_carry;
  logic [IdxW-1:0] r_idx;

  // Registered outputs.
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;
  logic [TotW-1:0] r_sum;
  logic            r_carry_out;

  logic            w_in_ready_nxt;
  logic            w_busy_nxt;
  logic            w_out_valid_nxt;

  // Handshake and slice signals.
  logic            w_accept;
  logic            w_release;
  logic            w_last_word;
  logic [Width:0]  w_slice;
  logic [TotW-1:0] w_res_shifted;
  logic [TotW-1:0] w_op2_load;
  logic            w_carry_init;

  // r_in_ready and r_out_valid are registered copies of the IDLE and DONE
  // decodes. Gating the handshakes with them keeps in_ready_o=0 in the first
  // cycle after reset, and no accept can happen in that cycle either.
  assign w_accept    = r_in_ready & in_valid_i;
  assign w_release   = r_out_valid & out_ready_i;
  assign w_last_word = (r_state == S_BUSY) && (r_idx == IdxLast);

  // One Width-bit ripple-carry slice. The low word of each operand register
  // is added to the chained carry.
  assign w_slice = {1'b0, r_op1[Width-1:0]} + {1'b0, r_op2[Width-1:0]}
                 + {{Width{1'b0}}, r_carry};

  // The slice sum enters at the top of the result register. After Words
  // shifts, the least-significant word ends up at the bottom.
  assign w_res_shifted = {w_slice[Width-1:0], r_res[TotW-1:Width]};

  // Selects the second operand and the initial carry for add or subtract.
`ifdef MWADD_SUB_EN
  always_comb begin
    w_op2_load   = add2_i;
    w_carry_init = 1'b0;
    if (sub_i) begin
      w_op2_load   = ~add2_i;
      w_carry_init = 1'b1;
    end else begin
      w_op2_load   = add2_i;
      w_carry_init = 1'b0;
    end
  end
`else
  always_comb begin
    w_op2_load   = add2_i;
    w_carry_init = 1'b0;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_idx == IdxLast) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode. It is taken from the next state so that the
  // registered flags line up with the state they describe.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_busy_nxt      = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_in_ready_nxt = 1'b1;
      end
      S_BUSY: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_out_valid_nxt = 1'b1;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_busy_nxt      = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Operand capture and word-serial datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op1   <= {TotW{1'b0}};
      r_op2   <= {TotW{1'b0}};
      r_res   <= {TotW{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= {IdxW{1'b0}};
    end else if (w_accept) begin
      r_op1   <= add1_i;
      r_op2   <= w_op2_load;
      r_carry <= w_carry_init;
      r_idx   <= {IdxW{1'b0}};
    end else if (r_state == S_BUSY) begin
      r_op1   <= {{Width{1'b0}}, r_op1[TotW-1:Width]};
      r_op2   <= {{Width{1'b0}}, r_op2[TotW-1:Width]};
      r_res   <= w_res_shifted;
      r_carry <= w_slice[Width];
      r_idx   <= r_idx + IdxOne;
    end else begin
      r_op1   <= r_op1;
      r_op2   <= r_op2;
      r_res   <= r_res;
      r_carry <= r_carry;
      r_idx   <= r_idx;
    end
  end

  // Result registers. They are loaded only on the final word, so sum_o and
  // carry_o keep the last completed result while the next operation runs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum       <= {TotW{1'b0}};
      r_carry_out <= 1'b0;
    end else if (w_last_word) begin
      r_sum       <= w_res_shifted;
      r_carry_out <= w_slice[Width];
    end else begin
      r_sum       <= r_sum;
      r_carry_out <= r_carry_out;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign busy_o      = r_busy;
  assign out_valid_o = r_out_valid;
  assign sum_o       = r_sum;
  assign carry_o     = r_carry_out;

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// Directed testbench for multiword_add_seq with Width=8 and Words=4.
// Every expected value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

  localparam int Width = 8;
  localparam int Words = 4;
  localparam int TotW  = Width * Words;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [TotW-1:0] add1;
  logic [TotW-1:0] add2;
  logic            out_valid;
  logic            out_ready;
  logic [TotW-1:0] sum;
  logic            carry;
  logic            busy;
`ifdef MWADD_SUB_EN
  logic            sub;
`endif

  int n_total;
  int n_bad;

  multiword_add_seq #(.Width(Width), .Words(Words)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
`ifdef MWADD_SUB_EN
    .sub_i       (sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .carry_o     (carry),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts the comparison and reports a mismatch.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation and waits for out_valid. Sampling happens on the
  // falling edge. Both the latency and the number of busy cycles are checked.
  task automatic run_op(input string tag, input logic [TotW-1:0] a,
                        input logic [TotW-1:0] b);
    int lat;
    int busy_cnt;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    add1 = a;
    add2 = b;
    @(posedge clk);              // E0 accept edge
    @(negedge clk);
    in_valid = 1'b0;
    add1 = 32'hDEAD_BEEF;
    add2 = 32'hDEAD_BEEF;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(Words));
    chk({tag, "_busycnt"}, 64'(busy_cnt), 64'(Words));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  // Completes the output handshake and checks the return to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_off"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int vld_seen;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    add1      = '0;
    add2      = '0;
`ifdef MWADD_SUB_EN
    sub       = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_sum",   64'(sum),       64'd0);
    chk("rst_carry", 64'(carry),     64'd0);
    chk("rst_ready", 64'(in_ready),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(in_ready), 64'd1);

    // Basic add.
    run_op("basic", 32'h0102_0304, 32'h1020_3040);
    chk("basic_sum", 64'(sum),   64'h1122_3344);
    chk("basic_c",   64'(carry), 64'd0);
    consume("basic");

    // Carry between bytes, but none out of the top.
    run_op("midc", 32'h00FF_00FF, 32'h0001_0001);
    chk("midc_sum", 64'(sum),   64'h0100_0100);
    chk("midc_c",   64'(carry), 64'd0);
    consume("midc");

    // Carry propagating through every word.
    run_op("chain", 32'hFFFF_FFFF, 32'h0000_0001);
    chk("chain_sum", 64'(sum),   64'h0);
    chk("chain_c",   64'(carry), 64'd1);
    consume("chain");

    run_op("top", 32'h8000_0000, 32'h8000_0000);
    chk("top_sum", 64'(sum),   64'h0);
    chk("top_c",   64'(carry), 64'd1);
    consume("top");

    // Backpressure. A new request during the stall is ignored.
    run_op("bp", 32'h1234_5678, 32'h1111_1111);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        add1 = 32'h0000_0001;
        add2 = 32'h0000_0001;
      end
      if (i == 6) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_sum",   64'(sum),       64'h2345_6789);
      chk("bp_vld",   64'(out_valid), 64'd1);
      chk("bp_rdy",   64'(in_ready),  64'd0);
      chk("bp_busy",  64'(busy),      64'd0);
    end
    consume("bp");
    @(negedge clk);
    chk("bp_after_busy", 64'(busy), 64'd0);
    chk("bp_after_sum",  64'(sum),  64'h2345_6789);

    // Reset during the second BUSY cycle.
    @(negedge clk);
    in_valid = 1'b1;
    add1 = 32'h0101_0101;
    add2 = 32'h0101_0101;
    @(posedge clk);              // E0
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);              // E1, now in the second BUSY cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy",  64'(busy),      64'd0);
    chk("mid_vld",   64'(out_valid), 64'd0);
    chk("mid_rdy",   64'(in_ready),  64'd0);
    chk("mid_sum",   64'(sum),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vld_seen++;
    end
    chk("mid_novld", 64'(vld_seen), 64'd0);
    run_op("post", 32'h0000_0005, 32'h0000_0003);
    chk("post_sum", 64'(sum),   64'h8);
    chk("post_c",   64'(carry), 64'd0);
    consume("post");

`ifdef MWADD_SUB_EN
    // Subtraction.
    sub = 1'b1;
    run_op("sub1", 32'h0000_0005, 32'h0000_0007);
    sub = 1'b0;
    chk("sub1_sum", 64'(sum),   64'hFFFF_FFFE);
    chk("sub1_c",   64'(carry), 64'd0);
    consume("sub1");
    sub = 1'b1;
    run_op("sub2", 32'h0000_0100, 32'h0000_0001);
    sub = 1'b0;
    chk("sub2_sum", 64'(sum),   64'h0000_00FF);
    chk("sub2_c",   64'(carry), 64'd1);
    consume("sub2");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
